dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: byte-address width of backing store (2^ADDR_WIDTH bytes, 32-bit words).
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request acceptance to rsp_valid; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  core presents a load/store request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  core accepts response.
REQ-013 SHALL have port rsp_rdata  output  32  load data, extended per funct3; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  access faulted (misaligned, illegal funct3, out of range).
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 SHALL assert req_ready only in IDLE; a request is accepted on a rising edge with req_valid & req_ready.
REQ-018 SHALL latch req_we, req_funct3, req_addr, req_wdata at acceptance; later input changes are ignored until return to IDLE.
REQ-019 SHALL go IDLE->WAIT on acceptance, load a latency counter, and enter RESP so that rsp_valid rises exactly LATENCY edges after the accept edge (LATENCY=1: WAIT lasts zero cycles, direct IDLE->RESP).
REQ-020 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_valid & rsp_ready at an edge, then go to IDLE; req_ready rises the cycle after that edge (no same-cycle re-accept).
REQ-021 SHALL flag error when funct3 is 011, 110 or 111; halfword with addr[0]=1; word with addr[1:0]!=00; or any of addr[31:ADDR_WIDTH] nonzero.
REQ-022 SHALL never modify storage on an errored store; errored responses return rsp_rdata=0, rsp_err=1.
REQ-023 SHALL commit a legal store on the edge entering RESP, writing only the addressed byte lanes (SB 1 lane addr[1:0], SH 2 lanes addr[1], SW 4 lanes).
REQ-024 SHALL read storage on the edge entering RESP and extend: LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-025 SHALL return rsp_rdata=0, rsp_err=0 for successful stores.
REQ-026 SHALL keep rsp_valid=0, rsp_err=0, rsp_rdata=0 in IDLE and WAIT.
REQ-027 SHALL tolerate rsp_ready held high in advance: response completes on the first RESP cycle.

Reset
REQ-028 SHALL, on rst asserted, immediately force state=IDLE, counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0; req_ready=1 once rst deasserts.
REQ-029 SHALL drop any in-flight request on reset; a store whose commit edge was not reached SHALL NOT be written.
REQ-030 SHALL NOT reset storage contents.

Verification
REQ-031 SW 0xDEADBEEF @0x10, then LW @0x10, LATENCY=2 -> each rsp_valid exactly 2 cycles after accept; LW returns 0xDEADBEEF, err=0.
REQ-032 After REQ-031: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x10 -> 0xFFFFBEEF; LHU @0x12 -> 0x0000DEAD.
REQ-033 SB 0x55 @0x11, then LW @0x10 -> 0xDEAD55EF; SH 0x1234 @0x12 -> LW 0x123455EF.
REQ-034 LW @0x11, SH @0x01, funct3=011 @0x0, SW @0x400 (ADDR_WIDTH=10) -> each err=1, rdata=0, memory unchanged.
REQ-035 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0; release -> IDLE, req_ready=1 next cycle.
REQ-036 Assert rst one cycle after accepting SW 0xAAAAAAAA @0x20 (LATENCY=3) -> outputs cleared asynchronously; subsequent LW @0x20 returns prior value.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-port data-memory responder for an RV32I core: one outstanding load/store,
// fixed request-to-response latency, byte-lane writes and sign/zero-extended reads.
//
// state | meaning
// IDLE  | ready for a request; response outputs held at zero
// WAIT  | request latched, latency counter running down to terminal count
// RESP  | response presented until the core takes it
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [3:0]  lat_cnt;
  logic        lat_we;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        accept;
  logic        enter_resp;
  logic        rsp_done;

  logic        op_we;
  logic [2:0]  op_funct3;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;

  logic                  op_err;
  logic [3:0]            op_be;
  logic [31:0]           op_wlane;
  logic [31:0]           load_val;
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [31:0]           rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic                  out_of_range;
  logic                  mem_we;

  logic [31:0] mem [0:DEPTH-1];

  assign accept     = req_valid && req_ready;
  assign rsp_done   = (state == RESP) && rsp_ready;
  assign enter_resp = (state_nxt == RESP) && (state != RESP);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt == 4'd0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = (state == IDLE) && !rst;
    busy      = (state != IDLE);
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt <= 4'd0;
    end else if (accept) begin
      lat_cnt <= CNT_LOAD;
    end else if ((state == WAIT) && (lat_cnt != 4'd0)) begin
      lat_cnt <= lat_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we     <= 1'b0;
      lat_funct3 <= 3'd0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
    end else if (accept) begin
      lat_we     <= req_we;
      lat_funct3 <= req_funct3;
      lat_addr   <= req_addr;
      lat_wdata  <= req_wdata;
    end
  end

  // With LATENCY=1 the commit edge is the accept edge, so the live request is used there.
  always_comb begin
    if (state == IDLE) begin
      op_we     = req_we;
      op_funct3 = req_funct3;
      op_addr   = req_addr;
      op_wdata  = req_wdata;
    end else begin
      op_we     = lat_we;
      op_funct3 = lat_funct3;
      op_addr   = lat_addr;
      op_wdata  = lat_wdata;
    end
  end

  assign word_idx     = op_addr[ADDR_WIDTH-1:2];
  assign out_of_range = |(op_addr >> ADDR_WIDTH);
  assign rd_word      = mem[word_idx];

  always_comb begin
    op_err   = out_of_range;
    op_be    = 4'b0000;
    op_wlane = 32'd0;
    unique case (op_funct3)
      F3_B, F3_BU: begin
        op_be    = 4'b0001 << op_addr[1:0];
        op_wlane = {4{op_wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        if (op_addr[0]) op_err = 1'b1;
        op_be    = op_addr[1] ? 4'b1100 : 4'b0011;
        op_wlane = {2{op_wdata[15:0]}};
      end
      F3_W: begin
        if (op_addr[1:0] != 2'b00) op_err = 1'b1;
        op_be    = 4'b1111;
        op_wlane = op_wdata;
      end
      default: op_err = 1'b1;
    endcase
  end

  always_comb begin
    rd_byte = rd_word[7:0];
    unique case (op_addr[1:0])
      2'd0: rd_byte = rd_word[7:0];
      2'd1: rd_byte = rd_word[15:8];
      2'd2: rd_byte = rd_word[23:16];
      2'd3: rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
    rd_half = op_addr[1] ? rd_word[31:16] : rd_word[15:0];
  end

  always_comb begin
    load_val = 32'd0;
    unique case (op_funct3)
      F3_B:    load_val = {{24{rd_byte[7]}}, rd_byte};
      F3_BU:   load_val = {24'd0, rd_byte};
      F3_H:    load_val = {{16{rd_half[15]}}, rd_half};
      F3_HU:   load_val = {16'd0, rd_half};
      F3_W:    load_val = rd_word;
      default: load_val = 32'd0;
    endcase
  end

  // Storage has no reset; gating with rst keeps a dropped store from landing.
  assign mem_we = enter_resp && op_we && !op_err && !rst;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && op_be[i]) begin
        mem[word_idx][8*i +: 8] <= op_wlane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_rdata <= (op_err || op_we) ? 32'd0 : load_val;
      rsp_err   <= op_err;
    end else if (rsp_done) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a byte-array reference model.
module tb_dmem_responder;

  localparam int AW  = 10;
  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb[$];
  logic [7:0] mem_b [0:(2**AW)-1];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit in_rsp = 0;
  exp_t cur;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: access size and signedness from funct3, bytes stored little-endian.
  function automatic logic [32:0] model(input bit we, input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] wd);
    int sz;
    bit uns;
    bit bad;
    logic [31:0] val;
    sz = 1; uns = 0; bad = 0;
    case (f3)
      3'b000: sz = 1;
      3'b001: sz = 2;
      3'b010: sz = 4;
      3'b100: begin sz = 1; uns = 1; end
      3'b101: begin sz = 2; uns = 1; end
      default: bad = 1;
    endcase
    if ((a % sz) != 0) bad = 1;
    if (a >= 2**AW) bad = 1;
    if (bad) return {1'b1, 32'h0};
    if (we) begin
      for (int i = 0; i < sz; i++) mem_b[a + i] = wd[8*i +: 8];
      return {1'b0, 32'h0};
    end
    val = 0;
    for (int i = 0; i < sz; i++) val = val | (32'(mem_b[a + i]) << (8 * i));
    if (!uns && sz < 4 && val[8*sz-1]) val = val | ~((32'd1 << (8 * sz)) - 32'd1);
    return {1'b0, val};
  endfunction

  // Monitor: pops one expectation per response, then watches it stay stable.
  always @(negedge clk) begin
    if (rst) begin
      in_rsp = 0;
    end else if (rsp_valid) begin
      if (!in_rsp) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          cur = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, cur.rd);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, cur.err});
          chk("rsp_latency", cyc - cur.acc, LAT);
        end
        in_rsp = 1;
      end else begin
        chk("rsp_rdata_stable", rsp_rdata, cur.rd);
        chk("rsp_err_stable", {31'd0, rsp_err}, {31'd0, cur.err});
      end
    end else begin
      in_rsp = 0;
      chk("idle_rdata_zero", rsp_rdata, 32'd0);
      chk("idle_err_zero", {31'd0, rsp_err}, 32'd0);
    end
  end

  // Driver; called and returns at a negedge.
  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int hold, input bit use_exp,
                       input logic [31:0] exp_rd, input bit exp_err);
    int t;
    logic [32:0] m;
    exp_t e;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
      return;
    end
    m = model(we, f3, a, wd);
    e.rd  = use_exp ? exp_rd : m[31:0];
    e.err = use_exp ? exp_err : m[32];
    e.acc = cyc;
    sb.push_back(e);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    rsp_ready  = (hold == 0);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rsp_valid && t < 50);
    if (!rsp_valid) begin
      chk("rsp_valid_timeout", 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_valid_after_done", {31'd0, rsp_valid}, 32'd0);
    chk("req_ready_after_done", {31'd0, req_ready}, 32'd1);
    rsp_ready = 1'b0;
  endtask

  logic [31:0] ra;
  logic [2:0]  rf;
  int          sz;
  logic [2:0]  legal_f3 [5];
  logic [2:0]  bad_f3 [3];

  initial begin
    legal_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    bad_f3   = '{3'b011, 3'b110, 3'b111};
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'd0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 2**(AW-2); i++)
      issue(1'b1, 3'b010, 32'(i * 4), $urandom, 0, 1'b0, 32'd0, 1'b0);

    issue(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 1, 32'h0, 0);
    issue(0, 3'b010, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF, 0);
    issue(0, 3'b000, 32'h13, 32'h0, 1, 1, 32'hFFFFFFDE, 0);
    issue(0, 3'b100, 32'h13, 32'h0, 0, 1, 32'h000000DE, 0);
    issue(0, 3'b001, 32'h10, 32'h0, 2, 1, 32'hFFFFBEEF, 0);
    issue(0, 3'b101, 32'h12, 32'h0, 0, 1, 32'h0000DEAD, 0);
    issue(1, 3'b000, 32'h11, 32'hFFFFFF55, 0, 1, 32'h0, 0);
    issue(0, 3'b010, 32'h10, 32'h0, 0, 1, 32'hDEAD55EF, 0);
    issue(1, 3'b001, 32'h12, 32'hABCD1234, 1, 1, 32'h0, 0);
    issue(0, 3'b010, 32'h10, 32'h0, 0, 1, 32'h123455EF, 0);
    issue(0, 3'b010, 32'h11, 32'h0, 0, 1, 32'h0, 1);
    issue(1, 3'b001, 32'h01, 32'hFFFFFFFF, 0, 1, 32'h0, 1);
    issue(1, 3'b011, 32'h00, 32'hFFFFFFFF, 0, 1, 32'h0, 1);
    issue(1, 3'b010, 32'h400, 32'hFFFFFFFF, 0, 1, 32'h0, 1);
    issue(0, 3'b010, 32'h00, 32'h0, 0, 0, 32'h0, 0);
    issue(0, 3'b010, 32'h10, 32'h0, 5, 1, 32'h123455EF, 0);
    issue(1, 3'b010, 32'h20, 32'h13579BDF, 0, 1, 32'h0, 0);

    // Store accepted, then reset before its commit edge: must be dropped.
    req_valid = 1'b1;
    req_we = 1'b1;
    req_funct3 = 3'b010;
    req_addr = 32'h20;
    req_wdata = 32'hAAAAAAAA;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_rdata", rsp_rdata, 32'd0);
    chk("async_rst_err", {31'd0, rsp_err}, 32'd0);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_req_ready", {31'd0, req_ready}, 32'd1);
    issue(0, 3'b010, 32'h20, 32'h0, 0, 1, 32'h13579BDF, 0);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) < 8) rf = legal_f3[$urandom_range(0, 4)];
      else rf = bad_f3[$urandom_range(0, 2)];
      ra = 32'($urandom_range(0, 2**AW - 1));
      sz = (rf[1:0] == 2'b10) ? 4 : (rf[1:0] == 2'b01) ? 2 : 1;
      if ($urandom_range(0, 3) != 0) ra = ra & ~32'(sz - 1);
      if ($urandom_range(0, 9) == 0) ra = ra | (32'd1 << $urandom_range(AW, 31));
      issue(1'($urandom), rf, ra, $urandom, $urandom_range(0, 3), 1'b0, 32'd0, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
